// File: rtl/vga_window_addr_gen.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_window_addr_gen
// Purpose  : Centred, zoomable framebuffer window addressing for vga_driver.
//            Optional 1-pixel border ring enabled by macro WIN_BORDER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module vga_window_addr_gen #(
  parameter int              H_ACTIVE     = 640,
  parameter int              V_ACTIVE     = 480,
  parameter int              IMG_W        = 160,
  parameter int              IMG_H        = 120,
  parameter int              MAX_SHIFT    = 2,
  parameter int              ADDR_W       = 19,
  parameter int              PIX_W        = 8,
  parameter int              RD_LAT       = 1,
  parameter logic [PIX_W-1:0] BORDER_COLOR = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              px_valid,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  input  logic              mode_valid,
  input  logic              mode_zoom_in,
  input  logic [1:0]        mode_shift,
  output logic              mode_ack,
  output logic              mode_err,
  input  logic              copy_done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  ram_q,
  output logic [PIX_W-1:0]  color_out,
  output logic              color_valid,
  output logic              in_window,
  output logic              frame_start,
  output logic [9:0]        win_w,
  output logic [9:0]        win_h
);

  localparam logic [9:0] DEF_W  = 10'(IMG_W * 2);
  localparam logic [9:0] DEF_H  = 10'(IMG_H * 2);
  localparam logic [9:0] DEF_XO = 10'((H_ACTIVE - IMG_W * 2) / 2);
  localparam logic [9:0] DEF_YO = 10'((V_ACTIVE - IMG_H * 2) / 2);

  logic [9:0]        win_w_q, win_h_q, x_off_q, y_off_q;
  logic              pend_q;
  logic [9:0]        pend_w_q, pend_h_q, pend_xo_q, pend_yo_q;
  logic              mode_ack_q, mode_err_q;
  logic [ADDR_W-1:0] row_base_q, last_addr_q;
  logic              rd_en_q, s1_val_q, s1_win_q, frame_start_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [RD_LAT-1:0] s2_val_q, s2_win_q, s2_rd_q;

  // Request geometry is evaluated wide so oversize requests cannot alias.
  logic [15:0] w_req_w, w_req_h;
  logic [9:0]  w_req_xo, w_req_yo;
  logic        w_req_bad;

  always_comb begin
    if (mode_zoom_in) begin
      w_req_w = 16'(IMG_W) << mode_shift;
      w_req_h = 16'(IMG_H) << mode_shift;
    end else begin
      w_req_w = 16'(IMG_W) >> mode_shift;
      w_req_h = 16'(IMG_H) >> mode_shift;
    end
    w_req_bad = (int'(mode_shift) > MAX_SHIFT) || (w_req_w > 16'(H_ACTIVE)) ||
                (w_req_h > 16'(V_ACTIVE)) || (w_req_w == 16'd0);
    w_req_xo  = 10'((16'(H_ACTIVE) - w_req_w) >> 1);
    w_req_yo  = 10'((16'(V_ACTIVE) - w_req_h) >> 1);
  end

  logic        w_sof, w_load, w_capture;
  logic [10:0] w_x, w_y, w_xo, w_yo, w_w, w_h;
  logic        w_hit, w_row_first, w_row_last;
  logic [ADDR_W-1:0] w_row_base, w_addr;
  logic        rd_en_d;
  logic [ADDR_W-1:0] rd_addr_d;

  assign w_sof     = px_valid && (next_x == 10'd0) && (next_y == 10'd0);
  assign w_load    = w_sof && pend_q;
  // mode_ack_q high means the requester's mode_valid is stale this cycle.
  assign w_capture = mode_valid && !pend_q && !mode_ack_q;

  // A mode switching in at (0,0) already governs that pixel.
  assign w_x  = {1'b0, next_x};
  assign w_y  = {1'b0, next_y};
  assign w_xo = {1'b0, w_load ? pend_xo_q : x_off_q};
  assign w_yo = {1'b0, w_load ? pend_yo_q : y_off_q};
  assign w_w  = {1'b0, w_load ? pend_w_q  : win_w_q};
  assign w_h  = {1'b0, w_load ? pend_h_q  : win_h_q};

  assign w_hit       = (w_x >= w_xo) && (w_x < w_xo + w_w) &&
                       (w_y >= w_yo) && (w_y < w_yo + w_h);
  assign w_row_first = (w_x == w_xo);
  assign w_row_last  = (w_x == w_xo + w_w - 11'd1);
  assign w_row_base  = w_sof ? '0 : row_base_q;
  assign w_addr      = w_row_first ? w_row_base : last_addr_q + ADDR_W'(1);

  assign rd_en_d   = px_valid && w_hit && copy_done;
  assign rd_addr_d = rd_en_d ? w_addr : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_w_q    <= DEF_W;
      win_h_q    <= DEF_H;
      x_off_q    <= DEF_XO;
      y_off_q    <= DEF_YO;
      pend_q     <= 1'b0;
      pend_w_q   <= '0;
      pend_h_q   <= '0;
      pend_xo_q  <= '0;
      pend_yo_q  <= '0;
      mode_ack_q <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      mode_ack_q <= 1'b0;
      mode_err_q <= 1'b0;
      if (w_load) begin
        win_w_q    <= pend_w_q;
        win_h_q    <= pend_h_q;
        x_off_q    <= pend_xo_q;
        y_off_q    <= pend_yo_q;
        pend_q     <= 1'b0;
        mode_ack_q <= 1'b1;
      end
      if (w_capture) begin
        if (w_req_bad) begin
          mode_ack_q <= 1'b1;
          mode_err_q <= 1'b1;
        end else begin
          pend_q    <= 1'b1;
          pend_w_q  <= w_req_w[9:0];
          pend_h_q  <= w_req_h[9:0];
          pend_xo_q <= w_req_xo;
          pend_yo_q <= w_req_yo;
        end
      end
    end
  end

  // Counting continues while copy_done is low so later rows stay aligned.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_base_q  <= '0;
      last_addr_q <= '0;
    end else if (px_valid) begin
      if (w_sof) begin
        row_base_q  <= '0;
        last_addr_q <= '0;
      end
      if (w_hit) begin
        last_addr_q <= w_addr;
        if (w_row_last) row_base_q <= w_row_base + ADDR_W'(w_w);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && px_valid && w_hit && !w_row_first)
      assert (last_addr_q != {ADDR_W{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q       <= 1'b0;
      rd_addr_q     <= '0;
      s1_val_q      <= 1'b0;
      s1_win_q      <= 1'b0;
      frame_start_q <= 1'b0;
      s2_val_q      <= '0;
      s2_win_q      <= '0;
      s2_rd_q       <= '0;
    end else begin
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      s1_val_q      <= px_valid;
      s1_win_q      <= px_valid && w_hit;
      frame_start_q <= w_sof;
      s2_val_q[0]   <= s1_val_q;
      s2_win_q[0]   <= s1_win_q;
      s2_rd_q[0]    <= rd_en_q;
      for (int i = 1; i < RD_LAT; i++) begin
        s2_val_q[i] <= s2_val_q[i-1];
        s2_win_q[i] <= s2_win_q[i-1];
        s2_rd_q[i]  <= s2_rd_q[i-1];
      end
    end
  end

`ifdef WIN_BORDER_EN
  // Off-screen ring positions never match a raster coordinate, so no clipping logic.
  logic              w_border;
  logic              s1_bord_q;
  logic [RD_LAT-1:0] s2_bord_q;

  always_comb begin
    w_border = !w_hit &&
      ((((w_x + 11'd1 == w_xo) || (w_x == w_xo + w_w)) &&
        (w_y + 11'd1 >= w_yo) && (w_y <= w_yo + w_h)) ||
       (((w_y + 11'd1 == w_yo) || (w_y == w_yo + w_h)) &&
        (w_x + 11'd1 >= w_xo) && (w_x <= w_xo + w_w)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_bord_q <= 1'b0;
      s2_bord_q <= '0;
    end else begin
      s1_bord_q    <= px_valid && w_border;
      s2_bord_q[0] <= s1_bord_q;
      for (int i = 1; i < RD_LAT; i++) s2_bord_q[i] <= s2_bord_q[i-1];
    end
  end

  assign color_out = s2_rd_q[RD_LAT-1]   ? ram_q :
                     s2_bord_q[RD_LAT-1] ? BORDER_COLOR : '0;
`else
  logic w_unused_border;
  assign w_unused_border = ^BORDER_COLOR;
  assign color_out = s2_rd_q[RD_LAT-1] ? ram_q : '0;
`endif

  assign mode_ack    = mode_ack_q;
  assign mode_err    = mode_err_q;
  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign color_valid = s2_val_q[RD_LAT-1];
  assign in_window   = s2_win_q[RD_LAT-1];
  assign frame_start = frame_start_q;
  assign win_w       = win_w_q;
  assign win_h       = win_h_q;

endmodule
`default_nettype wire

// File: doc/vga_window_addr_gen.md
Name: vga_window_addr_gen

Overview:
- Parametrised successor to the centred-image addressing in the VGA control unit.
- Takes raster coordinates from vga_driver and produces framebuffer read addresses for a centred image window.
- Window size is set by a run-time zoom direction and power-of-two factor. Mode changes go through a handshake and take effect only on a frame boundary.
- Addressing is incremental, with no multiplier. The pipeline stages in_window so it lines up with the RAM read data, and the block outputs the final pixel colour to vga_driver.

Parameters:
- H_ACTIVE, 640: visible columns.
- V_ACTIVE, 480: visible rows.
- IMG_W, 160: source image width.
- IMG_H, 120: source image height.
- MAX_SHIFT, 2: largest log2 zoom factor accepted.
- ADDR_W, 19: framebuffer address width.
- PIX_W, 8: pixel width.
- RD_LAT, 1: framebuffer read latency in cycles (1 or 2).
- BORDER_COLOR, 8'hFF: colour used by the optional border.

Ports:
- clk, in, 1: pixel clock (25 MHz).
- reset, in, 1: synchronous, active-high.
- px_valid, in, 1: next_x/next_y carry a new active pixel this cycle.
- next_x, in, 10: raster column.
- next_y, in, 10: raster row.
- mode_valid, in, 1: mode request; held until mode_ack.
- mode_zoom_in, in, 1: 1 = enlarge, 0 = reduce.
- mode_shift, in, 2: log2 of the zoom factor.
- mode_ack, out, 1: one-cycle pulse when the request is resolved.
- mode_err, out, 1: one-cycle pulse with mode_ack when the request is rejected.
- copy_done, in, 1: framebuffer content is valid.
- rd_en, out, 1: framebuffer read strobe.
- rd_addr, out, ADDR_W: framebuffer read address.
- ram_q, in, PIX_W: framebuffer read data.
- color_out, out, PIX_W: pixel colour to vga_driver.
- color_valid, out, 1: color_out corresponds to a px_valid pixel.
- in_window, out, 1: pixel lies in the window; aligned with color_out.
- frame_start, out, 1: pulse when pixel (0,0) is accepted.
- win_w, out, 10: active window width.
- win_h, out, 10: active window height.

Behaviour:
- Reset state:
  - All outputs are 0 except win_w/win_h.
  - Active mode is zoom-in, shift 1, so win_w = 320 and win_h = 240.
  - Offsets are x_off = 160, y_off = 120; they are valid in the first cycle after reset.
  - No pending request; row_base = 0; the pipeline is flushed.
- Window dimensions:
  - Zoom-in: W = IMG_W << s, H = IMG_H << s.
  - Zoom-out: W = IMG_W >> s, H = IMG_H >> s (truncating).
  - Offsets: x_off = (H_ACTIVE − W) >> 1, y_off = (V_ACTIVE − H) >> 1.
  - All arithmetic is 10-bit unsigned. Offsets are registered.
- Mode handshake:
  - A request is captured into the pending register on the first cycle of mode_valid while nothing is pending.
  - It is checked at capture and rejected if s > MAX_SHIFT, W > H_ACTIVE, H > V_ACTIVE, or W = 0.
  - On rejection, mode_ack and mode_err pulse on the following cycle and the active mode is unchanged.
  - A legal request stays pending until frame_start. In that cycle the new mode and offsets load, mode_ack pulses, and the pixel (0,0) is already evaluated with the new mode.
  - The requester drops mode_valid in the cycle after mode_ack. A stale mode_valid in that cycle is ignored.
- Addressing (per px_valid pixel):
  - win_hit = x_off ≤ x < x_off+W and y_off ≤ y < y_off+H, evaluated with the active mode.
  - The address counter resets to 0 and row_base resets to 0 at frame_start.
  - The first hit in a row loads addr = row_base. Each further hit gives addr+1.
  - The hit at x = x_off+W−1 sets row_base += W.
  - The last hit of the frame is addr = W·H−1. The counter never wraps within a frame; an overflow is a design error, covered by an assertion.
- Pipeline:
  - Stage 1 (1 cycle after px_valid): rd_addr/rd_en register. If not win_hit or copy_done = 0: rd_en = 0, rd_addr = 0.
  - Stage 2 (1+RD_LAT cycles after px_valid): color_out = ram_q if the delayed in_window is set, else 0. color_valid = delayed px_valid.
- Other cases:
  - px_valid = 0: no state advances; the pipeline still drains.
  - copy_done falling mid-frame: affected pixels output 0. The address counter keeps counting so alignment is kept when copy_done returns.
  - reset mid-frame: pipeline cleared, pending request dropped with no ack, defaults restored.

Optional Feature:
- Macro: WIN_BORDER_EN.
- When defined:
  - Pixels on the 1-pixel ring just outside the window (x = x_off−1 or x_off+W, y = y_off−1 or y_off+H, clipped to the screen) output BORDER_COLOR.
  - For those pixels color_valid = 1 and in_window = 0.
  - No read is issued for them.
- When undefined: those pixels output 0 and no border logic is built.

Test Plan:
- Reset, full frame with copy_done = 1 and the default mode:
  - First rd_addr = 0 at (160,120); (479,120) gives 319; (160,121) gives 320; last is 76799 at (479,359).
  - No rd_en outside the window.
- Request zoom-in with shift 2 mid-frame:
  - The current frame completes as 320×240.
  - mode_ack pulses at the next frame_start; win_w = 640, win_h = 480, x_off = 0; rd_addr at (639,479) = 307199.
- Request zoom-in with shift 3, then zoom-out with shift 0:
  - First request: mode_err and mode_ack the cycle after capture; the mode is unchanged.
  - Second request: accepted; 160×120 window at offset (240,180).
- RD_LAT = 2 with ram_q = (rd_addr & 8'hFF):
  - color_out equals the address's low byte exactly 3 cycles after px_valid.
  - in_window is aligned with it.
- Deassert copy_done for rows 200–209:
  - color_out = 0 and rd_en = 0 on those rows.
  - Row 210 resumes with the correct address 90·320 = 28800 at x = 160.
- Assert reset mid-frame with a request pending:
  - All outputs 0 next cycle; no mode_ack; defaults restored.
  - With WIN_BORDER_EN defined, (159,120) outputs 8'hFF.
